// File: rtl/adder_arbiter_seq.sv
// Two-requester sequential adder: a round-robin arbiter feeds one 8-bit adder
// slice that ripples the operand pair one byte per cycle, LSB first.
module adder_arbiter_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [8*NBYTES-1:0] req0_a,
    input  logic [8*NBYTES-1:0] req0_b,
    input  logic [8*NBYTES-1:0] req1_a,
    input  logic [8*NBYTES-1:0] req1_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_id,
    output logic [8*NBYTES-1:0] res_sum,
    output logic                res_cout
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NBYTES-1:0][7:0] a_q, a_d;
    logic [NBYTES-1:0][7:0] b_q, b_d;
    logic [NBYTES-1:0][7:0] sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   id_q, id_d;
    logic                   last_q, last_d;
    logic                   grant0, grant1;
    logic [7:0]             sliceA, sliceB;
    logic [8:0]             sliceOut;

    // The single byte-wide adder; every byte of every operation goes through it.
    always_comb begin
        sliceA   = a_q[idx_q];
        sliceB   = b_q[idx_q];
        sliceOut = {1'b0, sliceA} + {1'b0, sliceB} + {8'd0, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        id_d    = id_q;
        last_d  = last_q;
        grant0  = 1'b0;
        grant1  = 1'b0;

        case (state_q)
            IDLE: begin
                // last_q names the previous winner, so a tie goes to the other one.
                if (req0_valid && (!req1_valid || last_q)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q] = sliceOut[7:0];
                carry_d      = sliceOut[8];
                idx_d        = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Reset must hold both strobes low even though the state register already reads IDLE.
    assign req0_ready = grant0 & ~rst;
    assign req1_ready = grant1 & ~rst;
    assign res_valid  = (state_q == DONE);
    assign res_id     = id_q;
    assign res_sum    = sum_q;
    assign res_cout   = carry_q;

endmodule
